// File: rtl/i2s_tdm_multiline_receiver.sv
// Multi-line TDM/I2S capture: samples serial lines on the falling bit-clock edge,
// frames on fsync, and streams bits into a circular frame buffer with commit tracking.
module i2s_tdm_multiline_receiver #(
   parameter int DATA_LINES      = 1,
   parameter int FRAME_BITS_LOG2 = 8,
   parameter int CIRC_BUF_BITS   = 3,
   parameter int ERR_CNT_BITS    = 8
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     i2s_running_i,
   input  logic                                     i2s_fsync_i,
   input  logic [DATA_LINES-1:0]                    i2s_data_i,
   output logic [CIRC_BUF_BITS+FRAME_BITS_LOG2-1:0] ram_write_addr_o,
   output logic                                     ram_write_en_o,
   output logic [DATA_LINES-1:0]                    ram_write_data_o,
   output logic [CIRC_BUF_BITS-1:0]                 last_good_frame_idx_o,
   output logic                                     frame_valid_o,
   output logic                                     frame_done_o,
   output logic [ERR_CNT_BITS-1:0]                  sync_err_count_o
);

   localparam logic [FRAME_BITS_LOG2-1:0] POS_ZERO = '0;
   localparam logic [FRAME_BITS_LOG2-1:0] POS_ONE  = {{(FRAME_BITS_LOG2-1){1'b0}}, 1'b1};
   localparam logic [FRAME_BITS_LOG2-1:0] POS_LAST = '1;
   localparam logic [ERR_CNT_BITS-1:0]    ERR_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HUNT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t                     state_q;
   logic [CIRC_BUF_BITS-1:0]   slot_q;
   logic [FRAME_BITS_LOG2-1:0] pos_q;
   logic                       clean_q;
   logic [DATA_LINES-1:0]      data_q;
   logic                       fsync_q;

   // Inputs are launched by the far end on our rising edge, so sample mid-bit.
   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         fsync_q <= 1'b0;
      end else begin
         data_q  <= i2s_data_i;
         fsync_q <= i2s_fsync_i;
      end
   end

   // Write port contract: ram_write_en_o is a one-cycle strobe with no ready;
   // addr/data are valid only while it is high and the RAM must take every strobe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q               <= ST_IDLE;
         slot_q                <= '0;
         pos_q                 <= '0;
         clean_q               <= 1'b0;
         ram_write_addr_o      <= '0;
         ram_write_en_o        <= 1'b0;
         ram_write_data_o      <= '0;
         last_good_frame_idx_o <= '0;
         frame_valid_o         <= 1'b0;
         frame_done_o          <= 1'b0;
         sync_err_count_o      <= '0;
      end else begin
         ram_write_en_o <= 1'b0;
         frame_done_o   <= 1'b0;
         if (!i2s_running_i) begin
            // Stopping beats everything, including a commit due this cycle.
            state_q       <= ST_IDLE;
            pos_q         <= POS_ZERO;
            clean_q       <= 1'b0;
            frame_valid_o <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_HUNT;
               end
               ST_HUNT: begin
                  if (fsync_q) begin
                     ram_write_addr_o <= {slot_q, POS_ZERO};
                     ram_write_data_o <= data_q;
                     ram_write_en_o   <= 1'b1;
                     pos_q            <= POS_ONE;
                     clean_q          <= 1'b1;
                     state_q          <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (fsync_q && (pos_q != POS_ZERO)) begin
                     // Slip: restart the same slot at bit 0 with this bit.
                     ram_write_addr_o <= {slot_q, POS_ZERO};
                     ram_write_data_o <= data_q;
                     ram_write_en_o   <= 1'b1;
                     pos_q            <= POS_ONE;
                     clean_q          <= 1'b1;
                     if (sync_err_count_o != ERR_MAX)
                        sync_err_count_o <= sync_err_count_o + 1'b1;
                  end else if (!fsync_q && (pos_q == POS_ZERO)) begin
                     clean_q <= 1'b0;
                     state_q <= ST_HUNT;
                     if (sync_err_count_o != ERR_MAX)
                        sync_err_count_o <= sync_err_count_o + 1'b1;
                  end else begin
                     ram_write_addr_o <= {slot_q, pos_q};
                     ram_write_data_o <= data_q;
                     ram_write_en_o   <= 1'b1;
                     pos_q            <= pos_q + 1'b1;
                     if ((pos_q == POS_LAST) && clean_q) begin
                        last_good_frame_idx_o <= slot_q;
                        slot_q                <= slot_q + 1'b1;
                        frame_valid_o         <= 1'b1;
                        frame_done_o          <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
